// File: rtl/uart_tx_framer.sv
// UART transmit framer: serialises one word per handshake as
// start, LSB-first data, optional parity and one or two stop bits.
module uart_tx_framer #(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic [1:0]            tx_sel
);

  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  stop_hi_q, stop_hi_d;
  logic                  out_d, ready_d, busy_d, done_d;
  logic [1:0]            sel_d;
  logic                  accept;

  assign accept = tx_valid & tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      idx_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      stop_hi_q <= 1'b0;
      tx_out    <= IDLE_LEVEL;
      tx_sel    <= 2'b11;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      stop_hi_q <= stop_hi_d;
      tx_out    <= out_d;
      tx_sel    <= sel_d;
      tx_ready  <= ready_d;
      tx_busy   <= busy_d;
      tx_done   <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    idx_d     = idx_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    stop_hi_d = stop_hi_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A tick coinciding with accept is deliberately not consumed.
        if (accept) begin
          data_d    = tx_data;
          par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
          par_bit_d = (^tx_data) ^ (cfg_parity == 2'b10);
          stop2_d   = cfg_stop2;
          stop_hi_d = 1'b0;
          state_d   = S_ARM;
        end
      end
      S_ARM: begin
        if (baud_tick) state_d = S_START;
      end
      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (idx_q == LAST) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (baud_tick) begin
          if (stop2_q && !stop_hi_q) begin
            stop_hi_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they move with it.
  always_comb begin
    out_d   = IDLE_LEVEL;
    sel_d   = 2'b11;
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    unique case (state_d)
      S_START: begin
        out_d = ~IDLE_LEVEL;
        sel_d = 2'b00;
      end
      S_DATA: begin
        out_d = data_q[idx_d];
        sel_d = 2'b01;
      end
      S_PARITY: begin
        out_d = par_bit_q;
        sel_d = 2'b10;
      end
      default: begin
        out_d = IDLE_LEVEL;
        sel_d = 2'b11;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: table vectors, random
// frames against a frame model, and multi-cycle corner sequences.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, valid, stop2;
  logic [7:0] data;
  logic [1:0] par;
  logic       ready, out, busy, done;
  logic [1:0] sel;

  logic       tick5, valid5, stop5;
  logic [4:0] data5;
  logic [1:0] par5;
  logic       ready5, out5, busy5, done5;
  logic [1:0] sel5;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  uart_tx_framer #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .baud_tick(tick),
    .tx_valid(valid), .tx_data(data),
    .cfg_parity(par), .cfg_stop2(stop2),
    .tx_ready(ready), .tx_out(out), .tx_busy(busy),
    .tx_done(done), .tx_sel(sel)
  );

  uart_tx_framer #(.DATA_WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .baud_tick(tick5),
    .tx_valid(valid5), .tx_data(data5),
    .cfg_parity(par5), .cfg_stop2(stop5),
    .tx_ready(ready5), .tx_out(out5), .tx_busy(busy5),
    .tx_done(done5), .tx_sel(sel5)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] par;
    logic       s2;
    int         len;
    int         pbit;
    logic       tick_acc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  // Frame as a list of (line level, field) pairs from the frame rules.
  task automatic model(input logic [8:0] d, input int w,
                       input logic [1:0] p, input logic s2,
                       output logic [15:0] b, output logic [31:0] sl,
                       output int n);
    logic x;
    n = 0; b = '0; sl = '0; x = 1'b0;
    b[n] = 1'b0; sl[2*n +: 2] = 2'b00; n++;
    for (int i = 0; i < w; i++) begin
      b[n] = d[i]; sl[2*n +: 2] = 2'b01; x = x ^ d[i]; n++;
    end
    if (p == 2'b01 || p == 2'b10) begin
      b[n] = (p == 2'b10) ? ~x : x; sl[2*n +: 2] = 2'b10; n++;
    end
    for (int i = 0; i < (s2 ? 2 : 1); i++) begin
      b[n] = 1'b1; sl[2*n +: 2] = 2'b11; n++;
    end
  endtask

  // Entered at the negedge after the accepting edge; leaves at the
  // negedge of the tx_done cycle.
  task automatic check_frame(input logic [7:0] d, input logic [1:0] p,
                             input logic s2, input int len,
                             input int pbit, input int gapmax);
    logic [15:0] b;
    logic [31:0] sl;
    int n, gap;
    logic pout;
    logic [1:0] psel;
    model({1'b0, d}, 8, p, s2, b, sl, n);
    chk("arm_out", out, 1);
    chk("arm_sel", sel, 2'b11);
    chk("arm_busy", busy, 1);
    chk("arm_ready", ready, 0);
    pout = 1'b1; psel = 2'b11;
    for (int k = 0; k <= len; k++) begin
      gap = $urandom_range(gapmax, 0);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("hold_out", out, pout);
        chk("hold_sel", sel, psel);
        chk("hold_done", done, 0);
      end
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      if (k < len) begin
        chk($sformatf("bit%0d_out", k), out, b[k]);
        chk($sformatf("bit%0d_sel", k), sel, sl[2*k +: 2]);
        chk("frame_done", done, 0);
        chk("frame_ready", ready, 0);
        if (pbit >= 0 && k == 9) chk("parity_slot", out, pbit);
        pout = out; psel = sel;
      end else begin
        chk("end_done", done, 1);
        chk("end_ready", ready, 1);
        chk("end_busy", busy, 0);
        chk("end_out", out, 1);
        chk("end_sel", sel, 2'b11);
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input int gapmax,
                           input bit scramble);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", ready, 1);
    data = v.data; par = v.par; stop2 = v.s2;
    valid = 1'b1; tick = v.tick_acc;
    @(negedge clk);
    valid = 1'b0; tick = 1'b0;
    if (scramble) begin
      data = 8'($urandom); par = 2'($urandom); stop2 = 1'($urandom);
    end
    check_frame(v.data, v.par, v.s2, v.len, v.pbit, gapmax);
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("idle_ready", ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] e5_out;
    logic [17:0] e5_sel;
    vec_t r;
    vecs[0] = '{8'h55, 2'b01, 1'b0, 11, 0, 1'b0};
    vecs[1] = '{8'h07, 2'b10, 1'b0, 11, 0, 1'b0};
    vecs[2] = '{8'h07, 2'b01, 1'b0, 11, 1, 1'b1};
    vecs[3] = '{8'h07, 2'b00, 1'b0, 10, -1, 1'b0};
    vecs[4] = '{8'h07, 2'b11, 1'b0, 10, -1, 1'b1};
    vecs[5] = '{8'hFF, 2'b00, 1'b1, 11, -1, 1'b0};
    vecs[6] = '{8'h00, 2'b10, 1'b1, 12, 1, 1'b1};
    vecs[7] = '{8'h80, 2'b01, 1'b1, 12, 1, 1'b0};

    rst = 1'b1; tick = 0; valid = 0; data = 0; par = 0; stop2 = 0;
    tick5 = 0; valid5 = 0; data5 = 0; par5 = 0; stop5 = 0;
    @(negedge clk);
    chk("rst_out", out, 1);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sel", sel, 2'b11);
    chk("rst5_out", out5, 1);
    rst = 1'b0;

    repeat (3) begin
      tick = 1'b1;
      @(negedge clk);
      chk("idle_tick_sel", sel, 2'b11);
      chk("idle_tick_busy", busy, 0);
    end
    tick = 1'b0;

    for (int i = 0; i < 8; i++) run_frame(vecs[i], i % 3, 1'b1);

    for (int i = 0; i < 20; i++) begin
      r.data = 8'($urandom);
      r.par = 2'($urandom);
      r.s2 = 1'($urandom);
      r.len = 1 + 8 + ((r.par == 2'b01 || r.par == 2'b10) ? 1 : 0)
              + (r.s2 ? 2 : 1);
      r.pbit = -1;
      r.tick_acc = 1'($urandom);
      run_frame(r, 3, 1'b1);
    end

    // Back-to-back with tx_valid held high.
    @(negedge clk);
    data = 8'hA3; par = 2'b01; stop2 = 1'b0; valid = 1'b1;
    @(negedge clk);
    data = 8'h3C; par = 2'b10; stop2 = 1'b1;
    check_frame(8'hA3, 2'b01, 1'b0, 11, 0, 2);
    @(negedge clk);
    valid = 1'b0;
    check_frame(8'h3C, 2'b10, 1'b1, 12, 1, 0);
    @(negedge clk);
    chk("b2b_done_drop", done, 0);

    // Reset in the middle of the data field.
    data = 8'h55; par = 2'b00; stop2 = 1'b0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (6) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
    chk("pre_rst_sel", sel, 2'b01);
    rst = 1'b1;
    #1;
    chk("async_out", out, 1);
    chk("async_ready", ready, 1);
    chk("async_sel", sel, 2'b11);
    chk("async_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      tick = 1'b1;
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_out", out, 1);
    end
    tick = 1'b0;
    run_frame(vecs[0], 1, 1'b0);

    // Five-bit word with baud_tick tied high.
    e5_out = 9'b111100110;
    e5_sel = {2'b11, 2'b11, 2'b10, 2'b01, 2'b01, 2'b01,
              2'b01, 2'b01, 2'b00};
    tick5 = 1'b1;
    @(negedge clk);
    data5 = 5'h13; par5 = 2'b01; stop5 = 1'b1; valid5 = 1'b1;
    @(negedge clk);
    valid5 = 1'b0;
    chk("w5_arm_sel", sel5, 2'b11);
    chk("w5_arm_busy", busy5, 1);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("w5_bit%0d_out", k), out5, e5_out[k]);
      chk($sformatf("w5_bit%0d_sel", k), sel5, e5_sel[2*k +: 2]);
      chk("w5_done", done5, 0);
    end
    @(negedge clk);
    chk("w5_end_done", done5, 1);
    chk("w5_end_ready", ready5, 1);
    @(negedge clk);
    chk("w5_done_drop", done5, 0);
    tick5 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
Parametrised UART transmit framer. It accepts a parallel word over a valid/ready handshake and serialises it LSB-first as start, data, optional parity and stop bits, one bit per baud_tick. It holds the field sequencing state machine and the output field mux in one block. It sits between the TX holding logic/FIFO and the TX pin, and is driven by the shared baud-rate generator tick.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9.
IDLE_LEVEL, 1, line level in idle and stop; 1 = standard UART.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
baud_tick  input  1  one-clk strobe, one per bit period
tx_valid  input  1  word offered
tx_data  input  DATA_WIDTH  word to send; bit 0 sent first
cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none; sampled at accept
cfg_stop2  input  1  1 = two stop bits; sampled at accept
tx_ready  output  1  framer can accept a word
tx_out  output  1  serial line (registered)
tx_busy  output  1  frame in progress
tx_done  output  1  one-clk pulse at end of last stop bit
tx_sel  output  2  field being driven: 00 start, 01 data, 10 parity, 11 stop/idle

Behaviour:
- Reset (async, immediate): state IDLE, tx_out=IDLE_LEVEL, tx_ready=1, tx_busy=0, tx_done=0, tx_sel=11. Internal data/parity/count registers are cleared.
- Handshake: a word is accepted on a clk edge with tx_valid=1 and tx_ready=1. tx_ready=1 only in IDLE. At accept the block latches tx_data, cfg_parity and cfg_stop2, and computes parity over the DATA_WIDTH bits:
  - even: parity bit = XOR of the data bits;
  - odd: parity bit = inverse of that XOR.
- tx_valid while not ready is ignored. Data need not be held after accept.
- States:
  - IDLE: on accept go to ARM. tx_busy goes to 1 and tx_ready to 0 on the next cycle.
  - ARM: line stays idle. On baud_tick go to START. This aligns the start bit to the tick grid, so every bit lasts exactly one tick period.
  - START: tx_out=~IDLE_LEVEL, tx_sel=00. On baud_tick go to DATA with bit index 0.
  - DATA: tx_out=data[idx], tx_sel=01. On baud_tick: if idx==DATA_WIDTH-1, go to PARITY if parity is enabled, else STOP; otherwise idx+1.
  - PARITY: tx_out=parity bit, tx_sel=10. On baud_tick go to STOP.
  - STOP: tx_out=IDLE_LEVEL, tx_sel=11. On baud_tick: if cfg_stop2 was latched and this is the first stop bit, stay for a second bit; otherwise go to IDLE.
- tx_done: pulses 1 in the cycle after the baud_tick that ends the final stop bit. This is the same cycle tx_ready returns to 1.
- tx_out and tx_sel: registered, changing one clk after the baud_tick edge that advances the state.
- Frame length in ticks after ARM: 1 + DATA_WIDTH + (parity?1:0) + (stop2?2:1).
- Bit index: $clog2(DATA_WIDTH) bits wide, and never exceeds DATA_WIDTH-1.
- Boundaries:
  - baud_tick in IDLE is ignored.
  - baud_tick coinciding with accept is ignored; ARM then waits for the next tick.
  - Back-to-back: the next word can be accepted in the tx_done cycle. No idle gap beyond ARM waiting for its tick.
  - Config inputs changing mid-frame have no effect on the current frame.
  - rst mid-frame aborts immediately: line goes to IDLE_LEVEL and no tx_done is issued.
  - baud_tick held high continuously advances one bit per clk; this is legal and used for fast sim.

Test Plan:
1. DATA_WIDTH=8, tx_data=0x55, cfg_parity=01, cfg_stop2=0 -> after ARM, line per tick = 0,1,0,1,0,1,0,1,0, parity 0, stop 1 (11 ticks); tx_sel sequence 00,01x8,10,11; one tx_done pulse.
2. tx_data=0x07, parity odd then even -> parity bit 0 (odd), 1 (even); cfg_parity=00 -> no parity slot, 10-tick frame, tx_sel never 10.
3. cfg_stop2=1, tx_data=0xFF, no parity -> 0, eight 1s, then two stop ticks; tx_done only after the second stop tick; tx_ready low throughout.
4. Two words 0xA3 then 0x3C, tx_valid held high -> second accepted in the tx_done cycle; second start bit on the first tick after that; no corruption of the second frame.
5. Assert rst for 1 clk during the DATA bit at idx=4 -> tx_out=1 within the same cycle (async); tx_ready=1, no tx_done; a fresh 0x55 frame afterwards is correct.
6. DATA_WIDTH=5, baud_tick tied high, tx_data=5'h13, even parity -> 9 consecutive clk bits after ARM: 0,1,1,0,0,1, parity 1, stop 1, stop... (cfg_stop2=1 gives 2 stop bits).
